// File: rtl/ccff_chain_loader.sv
// Serialises a byte-wide bitstream into one ccff scan chain, MSB first,
// with a CRC-16-CCITT integrity check over the shifted bits.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int CNT_W     = 16
) (
    input  logic        prog_clk,
    input  logic        pReset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] crc_expected,
    input  logic [7:0]  bs_data,
    input  logic        bs_valid,
    output logic        bs_ready,
    output logic        ccff_head,
    output logic        config_enable,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic [15:0] crc_value,
    output logic        aborted
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [7:0]       shreg;
    logic [3:0]       buf_cnt;
    logic [15:0]      crc_q;
    logic [15:0]      crc_exp_q;
    logic             start_ok;
    logic             kill;
    logic             emit;
    logic             last_bit;
    logic             take;

    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic        b
    );
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign start_ok = (state == IDLE) && start && !abort;
    assign kill     = (state != IDLE) && abort;
    assign emit     = (state == SHIFT) && !abort
                    && (buf_cnt != 4'd0)
                    && (remaining != '0);
    assign last_bit = emit && (remaining == CNT_W'(1));
    assign take     = bs_valid && bs_ready;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (abort)         state_nxt = IDLE;
                else if (last_bit) state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Refill only once the buffer is down to its last bit, and never
    // fetch a byte whose bits would all fall beyond the chain end.
    always_comb begin
        busy     = (state != IDLE);
        bs_ready = (state == SHIFT)
                && (buf_cnt <= 4'd1)
                && (remaining > CNT_W'(buf_cnt));
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            remaining     <= '0;
            shreg         <= '0;
            buf_cnt       <= '0;
            crc_q         <= 16'hFFFF;
            crc_exp_q     <= '0;
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
            done          <= 1'b0;
            crc_ok        <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            config_enable <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            if (start_ok) begin
                remaining <= LEN;
                crc_q     <= 16'hFFFF;
                crc_exp_q <= crc_expected;
                crc_ok    <= 1'b0;
                buf_cnt   <= '0;
                shreg     <= '0;
            end else if (kill) begin
                aborted   <= 1'b1;
                remaining <= '0;
                buf_cnt   <= '0;
                shreg     <= '0;
            end else if (state == CHECK) begin
                crc_ok  <= (crc_q == crc_exp_q);
                done    <= 1'b1;
                buf_cnt <= '0;
                shreg   <= '0;
            end else if (state == SHIFT) begin
                if (emit) begin
                    ccff_head     <= shreg[7];
                    config_enable <= 1'b1;
                    remaining     <= remaining - CNT_W'(1);
                    crc_q         <= crc_step(crc_q, shreg[7]);
                end
                if (take) begin
                    shreg   <= bs_data;
                    buf_cnt <= 4'd8;
                end else if (emit) begin
                    shreg   <= {shreg[6:0], 1'b0};
                    buf_cnt <= buf_cnt - 4'd1;
                end
            end
        end
    end

    assign crc_value = crc_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader against a bit-list / CRC model.
// Covers stalls, abort, async reset, restart attempts and an 8-bit chain.
module tb_ccff_chain_loader;

    localparam int CL = 36;

    logic        clk = 1'b0;
    logic        pReset;
    logic        start, abort, bs_valid;
    logic [15:0] crc_expected;
    logic [7:0]  bs_data;
    logic        bs_ready, ccff_head, config_enable;
    logic        busy, done, crc_ok, aborted;
    logic [15:0] crc_value;

    logic        s_start, s_abort, s_valid;
    logic [15:0] s_exp;
    logic [7:0]  s_data;
    logic        s_ready, s_head, s_ce, s_busy, s_done, s_ok, s_ab;
    logic [15:0] s_crc;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] stream [5];

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(CL), .CNT_W(16)) dut (
        .prog_clk(clk), .pReset(pReset), .start(start), .abort(abort),
        .crc_expected(crc_expected), .bs_data(bs_data),
        .bs_valid(bs_valid), .bs_ready(bs_ready),
        .ccff_head(ccff_head), .config_enable(config_enable),
        .busy(busy), .done(done), .crc_ok(crc_ok),
        .crc_value(crc_value), .aborted(aborted)
    );

    ccff_chain_loader #(.CHAIN_LEN(8), .CNT_W(4)) dut8 (
        .prog_clk(clk), .pReset(pReset), .start(s_start), .abort(s_abort),
        .crc_expected(s_exp), .bs_data(s_data),
        .bs_valid(s_valid), .bs_ready(s_ready),
        .ccff_head(s_head), .config_enable(s_ce),
        .busy(s_busy), .done(s_done), .crc_ok(s_ok),
        .crc_value(s_crc), .aborted(s_ab)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic stream_bit(input int i);
        logic [7:0] b;
        b = stream[i / 8];
        return b[7 - (i % 8)];
    endfunction

    function automatic logic [15:0] crc_ref(input int n);
        int c;
        int b;
        c = 'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = int'(stream_bit(i));
            if ((((c >> 15) & 1) ^ b) != 0)
                c = ((c << 1) ^ 'h1021) & 'hFFFF;
            else
                c = (c << 1) & 'hFFFF;
        end
        return c[15:0];
    endfunction

    task automatic check_reset_outs(input string tag);
        check({tag, "_outs"},
              {ccff_head, config_enable, busy, bs_ready,
               done, crc_ok, aborted}, 64'd0);
        check({tag, "_crc"}, crc_value, 64'hFFFF);
    endtask

    task automatic do_load(input int stall_at, input int stall_len,
                           input int abort_bit, input int restart_bit,
                           input int rst_bit, input logic [15:0] cexp);
        int idx = 0, nen = 0, nacc = 0, cyc = 0, stc = 0;
        int first = -1, last = -1, dcnt = 0, dcyc = -1;
        bit fin = 0, early = 0, rs_done = 0;
        logic [63:0] gotv = '0;
        logic [63:0] expv = '0;
        logic [15:0] mcrc;
        start = 1'b1;
        crc_expected = cexp;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_okclr", crc_ok, 0);
        while (!fin && cyc < 200) begin
            if (config_enable) begin
                gotv = {gotv[62:0], ccff_head};
                if (first < 0) first = cyc;
                last = cyc;
                nen++;
            end
            if (done) begin
                dcnt++;
                dcyc = cyc;
                fin = 1;
            end
            if (!fin && abort_bit > 0 && nen == abort_bit) begin
                start = 1'b0;
                abort = 1'b1;
                bs_valid = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                check("ab_ce", config_enable, 0);
                check("ab_pulse", aborted, 1);
                check("ab_busy", busy, 0);
                check("ab_ready", bs_ready, 0);
                check("ab_ok", crc_ok, 0);
                check("ab_nen", nen, abort_bit);
                @(negedge clk);
                check("ab_one", aborted, 0);
                check("ab_done", done, 0);
                fin = 1;
                early = 1;
            end else if (!fin && rst_bit > 0 && nen == rst_bit) begin
                start = 1'b0;
                bs_valid = 1'b0;
                #2 pReset = 1'b1;
                #1 check_reset_outs("midrst");
                @(negedge clk);
                pReset = 1'b0;
                fin = 1;
                early = 1;
            end else if (!fin) begin
                start = (restart_bit > 0 && nen == restart_bit && !rs_done);
                if (start) rs_done = 1;
                bs_valid = 1'b0;
                if (idx < 5) begin
                    if (idx == stall_at && stc < stall_len && bs_ready) begin
                        stc++;
                    end else begin
                        bs_valid = 1'b1;
                        bs_data = stream[idx];
                    end
                end
                if (bs_valid && bs_ready) begin
                    idx++;
                    nacc++;
                end
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        bs_valid = 1'b0;
        check("load_fin", fin, 1);
        if (!early) begin
            for (int i = 0; i < CL; i++)
                expv = {expv[62:0], stream_bit(i)};
            mcrc = crc_ref(CL);
            check("bits", gotv, expv);
            check("nen", nen, CL);
            check("nacc", nacc, 5);
            check("ndone", dcnt, 1);
            check("done_lat", dcyc, last + 1);
            check("gaps", last - first + 1 - nen, stall_len);
            check("crc_val", crc_value, mcrc);
            check("crc_ok", crc_ok, mcrc == cexp);
            @(negedge clk);
            check("done_pulse", done, 0);
            check("ok_hold", crc_ok, mcrc == cexp);
            check("idle", busy, 0);
        end
    endtask

    initial begin
        logic [15:0] gold;
        pReset = 1'b1;
        start = 0; abort = 0; bs_valid = 0;
        bs_data = '0; crc_expected = '0;
        s_start = 0; s_abort = 0; s_valid = 0;
        s_data = '0; s_exp = '0;
        #3 check_reset_outs("reset");
        @(negedge clk);
        @(negedge clk);
        pReset = 1'b0;
        @(negedge clk);

        stream[0] = 8'hA5; stream[1] = 8'h3C; stream[2] = 8'hFF;
        stream[3] = 8'h00; stream[4] = 8'h96;
        gold = crc_ref(CL);
        do_load(0, 0, 0, 0, 0, gold);
        do_load(2, 3, 0, 0, 0, gold);
        stream[1] = stream[1] ^ 8'h10;
        do_load(0, 0, 0, 0, 0, gold);
        stream[1] = stream[1] ^ 8'h10;

        do_load(0, 0, 20, 0, 0, gold);
        do_load(0, 0, 0, 0, 0, gold);
        do_load(0, 0, 0, 0, 15, gold);
        do_load(0, 0, 0, 10, 0, gold);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_idle", {busy, aborted, done, config_enable}, 0);
        @(negedge clk);
        check("sa_idle2", {busy, aborted, done}, 0);

        for (int t = 0; t < 10; t++) begin
            logic [15:0] ce;
            for (int k = 0; k < 5; k++)
                stream[k] = 8'($urandom);
            ce = crc_ref(CL);
            if ($urandom_range(0, 1) == 1)
                ce = ce ^ (16'h1 << $urandom_range(0, 15));
            do_load($urandom_range(1, 4), $urandom_range(0, 4),
                    0, 0, 0, ce);
        end

        begin
            int n8 = 0, a8 = 0, d8 = 0, cyc = 0;
            bit taken = 0;
            logic [7:0] bits8 = '0;
            stream[0] = 8'h80;
            s_exp = crc_ref(8);
            s_start = 1'b1;
            @(negedge clk);
            s_start = 1'b0;
            while (d8 == 0 && cyc < 50) begin
                if (s_ce) begin
                    bits8 = {bits8[6:0], s_head};
                    n8++;
                end
                if (s_done) d8++;
                s_valid = !taken;
                s_data = 8'h80;
                if (s_valid && s_ready) begin
                    taken = 1;
                    a8++;
                end
                cyc++;
                @(negedge clk);
            end
            s_valid = 1'b0;
            check("c8_bits", bits8, 8'h80);
            check("c8_nen", n8, 8);
            check("c8_acc", a8, 1);
            check("c8_done", d8, 1);
            check("c8_crc", s_crc, crc_ref(8));
            check("c8_ok", s_ok, 1);
            @(negedge clk);
            check("c8_pulse", s_done, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
